osc_sweep_ctrl: RTL
===================

# osc_sweep_ctrl

Sequencer that exhaustively sweeps the primary inputs of a gate-level combinational block under test and classifies each input vector as stable or oscillating. It drives the vector, waits a settle interval, then counts transitions on a probe net (for example a loop-closure net or oscillation flag) over an observation window. It reports one result per vector over a valid/ready handshake. It replaces free-running toggle-register stimulus with a clocked, repeatable, back-pressurable sweep.

## Interface
Parameters:
- N, 8, number of DUT inputs swept; vectors 0 .. 2^N-1
- SETTLE, 4, cycles a new vector is held before observation starts (>=1)
- WINDOW, 16, observation cycles per vector (>=1)
- OSC_THR, 2, toggle count at or above which a vector is flagged oscillating (1..WINDOW)
- CW (localparam), clog2(WINDOW+1), toggle-counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sweep from vector 0 (sampled in IDLE only)
- abort  in  1  synchronous abort, any state
- vec_out  out  N  vector driven to DUT inputs
- probe_in  in  1  asynchronous probe from DUT; 2-flop synchronised internally
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on sweep completion
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_vec  out  N  vector the result belongs to
- res_toggles  out  CW  synchronised probe transitions counted in window
- res_osc  out  1  res_toggles >= OSC_THR
- osc_count  out  N+1  number of oscillating vectors in current/last sweep

## Operation
- States: IDLE, APPLY, OBSERVE, REPORT, DONE.
- IDLE: start=1 -> APPLY; vec_out<=0, osc_count<=0, settle counter cleared.
- APPLY: held for exactly SETTLE cycles, then -> OBSERVE. On OBSERVE entry, the previous-sample register is loaded with the current synchronised probe value and the toggle counter is cleared. No spurious edge is counted at entry.
- OBSERVE: held for exactly WINDOW cycles. Each cycle, synchronised probe != previous sample -> toggle counter +1, saturating at WINDOW. Then -> REPORT.
- REPORT: res_valid=1. res_vec, res_toggles and res_osc are registered on REPORT entry and stay stable while res_valid=1. On res_valid&&res_ready:
  - osc_count += res_osc;
  - if vec_out == 2^N-1 -> DONE;
  - else vec_out<=vec_out+1 -> APPLY.
- DONE: done=1 for one cycle -> IDLE. vec_out keeps its last vector. osc_count holds until the next start.
- vec_out changes only on IDLE->APPLY and REPORT->APPLY edges.
- start while busy: ignored.
- abort (priority over all other transitions): next state IDLE, res_valid<=0, no done pulse, vec_out and osc_count hold. start and abort together in IDLE: abort wins, stay IDLE.
- Vector increment wraps nowhere; the sweep terminates at 2^N-1. N+1-bit osc_count cannot overflow.

## Timing
- Reset values: vec_out=0, busy=0, done=0, res_valid=0, res_vec=0, res_toggles=0, res_osc=0, osc_count=0, state IDLE, synchroniser flops 0.
- start high at edge k -> vec_out valid and busy=1 after edge k.
- vec_out change at edge t -> res_valid=1 after edge t+SETTLE+WINDOW.
- With res_ready held 1: SETTLE+WINDOW+1 cycles per vector; full sweep = 2^N*(SETTLE+WINDOW+1) cycles from start to done.
- done is asserted the cycle after the final handshake; busy falls with done's falling edge (IDLE).
- Probe synchroniser latency is 2 cycles. Transitions in the final 2 cycles of APPLY are attributed to the window. SETTLE must cover DUT settling plus 2 cycles.
- Async reset mid-sweep: all outputs return to reset values immediately; no result or done is emitted.

## Test plan
- N=2, probe_in tied 0, res_ready=1, start pulse -> four results with res_vec 0,1,2,3, res_toggles=0, res_osc=0; done after 4*(4+16+1)=84 cycles; osc_count=0.
- N=2, probe toggles every 4 clocks only while vec_out==3 -> result 3 has res_toggles=4, res_osc=1; others 0; final osc_count=1.
- res_ready held 0 for 10 cycles in REPORT -> res_valid, res_vec and res_toggles stable; vec_out unchanged; advances one cycle after res_ready=1.
- abort asserted mid-OBSERVE of vector 5 -> IDLE next cycle, busy=0, res_valid=0, no done; a new start restarts at vec_out=0 with osc_count=0.
- start pulsed during APPLY of vector 2 -> no effect; sweep continues to vector 3 normally.
- rst_n low for one cycle mid-REPORT -> res_valid=0, vec_out=0 and osc_count=0 immediately; IDLE after release.

Source files
------------

// File: rtl/osc_sweep_if.sv
// Result channel of osc_sweep_ctrl: one classification per swept vector,
// moved with a valid/ready handshake.
interface osc_sweep_if #(
    parameter int N  = 8,
    parameter int CW = 5
);
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_vec;
    logic [CW-1:0] res_toggles;
    logic          res_osc;

    modport master (
        output res_valid, res_vec, res_toggles, res_osc,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_vec, res_toggles, res_osc,
        output res_ready
    );
endinterface

// File: rtl/osc_sweep_ctrl.sv
// Exhaustive input sweep for a combinational block: drive each vector, let it
// settle, count synchronised probe transitions over a window, report the result.
module osc_sweep_ctrl #(
    parameter int N       = 8,
    parameter int SETTLE  = 4,
    parameter int WINDOW  = 16,
    parameter int OSC_THR = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    output logic [N-1:0] vec_out,
    input  logic         probe_in,
    output logic         busy,
    output logic         done,
    osc_sweep_if.master  res,
    output logic [N:0]   osc_count
);
    localparam int CW  = $clog2(WINDOW + 1);
    localparam int SCW = $clog2(SETTLE + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_APPLY   = 3'd1;
    localparam logic [2:0] S_OBSERVE = 3'd2;
    localparam logic [2:0] S_REPORT  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
    localparam logic [CW-1:0]  WIN_LAST    = CW'(WINDOW - 1);
    localparam logic [CW-1:0]  WIN_MAX     = CW'(WINDOW);
    localparam logic [CW-1:0]  THR         = CW'(OSC_THR);

    logic [2:0]     r_state;
    logic [N-1:0]   r_vec;
    logic [N:0]     r_osc_count;
    logic [SCW-1:0] r_settle_cnt;
    logic [CW-1:0]  r_win_cnt;
    logic [CW-1:0]  r_toggles;
    logic           r_sync1;
    logic           r_sync2;
    logic           r_prev;
    logic [N-1:0]   r_res_vec;
    logic [CW-1:0]  r_res_toggles;
    logic           r_res_osc;

    logic           w_edge;
    logic [CW-1:0]  w_tog_next;

    // NOTE: non-blocking assignments so both flops shift on the same edge;
    // blocking would collapse the two stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= probe_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_edge     = r_sync2 ^ r_prev;
    assign w_tog_next = (w_edge && (r_toggles != WIN_MAX)) ? r_toggles + 1'b1 : r_toggles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_vec         <= '0;
            r_osc_count   <= '0;
            r_settle_cnt  <= '0;
            r_win_cnt     <= '0;
            r_toggles     <= '0;
            r_prev        <= 1'b0;
            r_res_vec     <= '0;
            r_res_toggles <= '0;
            r_res_osc     <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: the default arm returns to IDLE so an illegal encoding
            // cannot wedge the sequencer.
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_APPLY;
                        r_vec        <= '0;
                        r_osc_count  <= '0;
                        r_settle_cnt <= '0;
                    end
                end
                S_APPLY: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        // Seed the edge detector so window entry is never an edge.
                        r_state   <= S_OBSERVE;
                        r_prev    <= r_sync2;
                        r_toggles <= '0;
                        r_win_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                S_OBSERVE: begin
                    r_prev    <= r_sync2;
                    r_toggles <= w_tog_next;
                    if (r_win_cnt == WIN_LAST) begin
                        r_state       <= S_REPORT;
                        r_res_vec     <= r_vec;
                        r_res_toggles <= w_tog_next;
                        r_res_osc     <= (w_tog_next >= THR);
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                    end
                end
                S_REPORT: begin
                    if (res.res_ready) begin
                        r_osc_count <= r_osc_count + {{N{1'b0}}, r_res_osc};
                        if (r_vec == '1) begin
                            r_state <= S_DONE;
                        end else begin
                            r_vec        <= r_vec + 1'b1;
                            r_settle_cnt <= '0;
                            r_state      <= S_APPLY;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vec_out         = r_vec;
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign osc_count       = r_osc_count;
    assign res.res_valid   = (r_state == S_REPORT);
    assign res.res_vec     = r_res_vec;
    assign res.res_toggles = r_res_toggles;
    assign res.res_osc     = r_res_osc;

endmodule
